dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Blocking controller that sequences the data-cache array for one load port and one store port.
- Arbitrates between the two requesters and runs the array lookup.
- On a miss, writes back a dirty victim, issues the fill to memory, tracks the 4-bit memory transaction tag, installs the returned block and answers the requester.
- Sits between the LSQ and the cache array / memory interface.
- Line size is one 64-bit block; stores write a full block.

Parameters:
- INDEX_BITS, 5, set-index width.
- TAG_BITS, 8, address tag width. Address width is TAG_BITS+INDEX_BITS+3.
- CNT_W, 32, width of the hit and miss statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ld_req_valid  in  1  load request
- ld_req_addr  in  TAG_BITS+INDEX_BITS+3  load byte address
- ld_req_ready  out  1  load accepted when valid&&ready
- ld_resp_valid  out  1  one-cycle pulse, load data valid
- ld_resp_data  out  64  load block
- st_req_valid  in  1  store request
- st_req_addr  in  TAG_BITS+INDEX_BITS+3  store byte address
- st_req_data  in  64  store block
- st_req_ready  out  1  store accepted when valid&&ready
- st_done  out  1  one-cycle pulse, store committed to cache
- cache_index  out  INDEX_BITS  array set select
- cache_tag  out  TAG_BITS  array lookup tag
- cache_lookup  out  1  array lookup strobe
- cache_hit  in  1  combinational hit for current lookup
- cache_rd_data  in  64  hit data
- cache_victim_dirty  in  1  LRU victim of set is valid and dirty
- cache_victim_tag  in  TAG_BITS  victim tag
- cache_victim_data  in  64  victim block
- cache_wr_en  out  1  write hit way: data=cache_wr_data, dirty=1
- cache_fill_en  out  1  install into LRU way: tag=cache_tag, data=cache_wr_data, valid=1, dirty=cache_fill_dirty
- cache_fill_dirty  out  1  dirty bit for the fill
- cache_wr_data  out  64  write/fill data
- proc2mem_command  out  2  0 NONE, 1 LOAD, 2 STORE
- proc2mem_addr  out  TAG_BITS+INDEX_BITS+3  block-aligned address
- proc2mem_data  out  64  writeback data
- mem2proc_response  in  4  nonzero = command accepted; value is the transaction tag
- mem2proc_data  in  64  returned block
- mem2proc_tag  in  4  tag of returned block; 0 = none
- busy  out  1  FSM not in IDLE
- hit_count  out  CNT_W  lookups that hit
- miss_count  out  CNT_W  lookups that missed

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pending_tag=0, rr_last=store. The last makes load win the first tie.
- Reset mid-operation aborts any transaction. No response pulse is produced, and no memory command is driven in the cycle after reset.
- States: IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESP.
- IDLE arbitration:
  - ready is asserted combinationally only in IDLE, to a single winner.
  - If only one port is valid, that port wins.
  - If both are valid, the port not served last wins.
  - On accept, latch op, address and store data; rr_last is set to the winner; go to LOOKUP.
  - Acceptance requires only valid&&ready; no dependence on ready->valid paths.
- LOOKUP: single cycle; cache_lookup=1 with the latched index/tag.
  - Hit, load: latch cache_rd_data; go to RESP.
  - Hit, store: cache_wr_en=1 this cycle with the store data; go to RESP.
  - Hit: hit_count increments.
  - Miss: miss_count increments. Victim dirty goes to WB_REQ (latch victim tag/data); otherwise go to FILL_REQ.
  - Counters wrap on overflow.
- WB_REQ:
  - Drive command=STORE, addr={victim_tag,index,3'b0}, data=victim data.
  - Hold until mem2proc_response!=0, then go to FILL_REQ.
  - The writeback tag is not tracked.
- FILL_REQ:
  - Drive command=LOAD, addr={tag,index,3'b0}.
  - On mem2proc_response!=0, latch it into pending_tag and go to FILL_WAIT.
  - On response 0, re-issue the identical command next cycle.
- FILL_WAIT:
  - command=NONE.
  - When mem2proc_tag==pending_tag and pending_tag!=0:
    - Assert cache_fill_en for one cycle.
    - Load fill: cache_wr_data=mem2proc_data, fill_dirty=0; latch mem2proc_data for the response.
    - Store fill: cache_wr_data=store data, fill_dirty=1.
    - Clear pending_tag; go to RESP.
  - mem2proc_tag values that do not match are ignored.
- RESP:
  - Pulse ld_resp_valid with the latched data, or pulse st_done.
  - Next state IDLE, so back-to-back accepts are spaced by at least 3 cycles.
- Latency, accept to response pulse:
  - Hit: 2 cycles.
  - Clean miss: 4 + memory accept stalls + memory latency.
  - busy=1 in every state except IDLE.

Test Plan:
- Load hit: array hit with data 0xDEADBEEF_00000001, load at 0x0140 → ld_req_ready=1 at accept; ld_resp_valid exactly 2 cycles later with that data; hit_count=1; no memory command.
- Clean load miss: miss, victim clean, memory returns response 3 then tag 3 after 10 cycles with 0x1234 → one LOAD to block-aligned address; cache_fill_en with fill_dirty=0 and data 0x1234; ld_resp_valid next cycle; miss_count=1.
- Dirty store miss: store 0xAA at 0x0248, victim dirty with tag 0x5A, data 0x77 → STORE of 0x77 to {0x5A,index,000}; then LOAD; on tag match, fill with data 0xAA and fill_dirty=1; st_done pulse.
- Memory backpressure and foreign tags: response 0 for 4 cycles then 7; mem2proc_tag shows 2 then 7 → LOAD held for 5 cycles; tag 2 ignored; fill only on tag 7.
- Arbitration: both ports valid continuously with hits → grants alternate load, store, load, store; first grant after reset goes to load.
- Reset in FILL_WAIT with pending_tag 9, then tag 9 returned after reset → no fill, no response pulse, busy=0, outputs zero.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Blocking data-cache sequencer for one load and one store port: arbitration, lookup,
// dirty writeback, tagged fill and response. Only one request is in flight at a time.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 8,
  parameter int CNT_W      = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ld_req_valid,
  input  logic [TAG_BITS+INDEX_BITS+2:0]     ld_req_addr,
  output logic                               ld_req_ready,
  output logic                               ld_resp_valid,
  output logic [63:0]                        ld_resp_data,
  input  logic                               st_req_valid,
  input  logic [TAG_BITS+INDEX_BITS+2:0]     st_req_addr,
  input  logic [63:0]                        st_req_data,
  output logic                               st_req_ready,
  output logic                               st_done,
  output logic [INDEX_BITS-1:0]              cache_index,
  output logic [TAG_BITS-1:0]                cache_tag,
  output logic                               cache_lookup,
  input  logic                               cache_hit,
  input  logic [63:0]                        cache_rd_data,
  input  logic                               cache_victim_dirty,
  input  logic [TAG_BITS-1:0]                cache_victim_tag,
  input  logic [63:0]                        cache_victim_data,
  output logic                               cache_wr_en,
  output logic                               cache_fill_en,
  output logic                               cache_fill_dirty,
  output logic [63:0]                        cache_wr_data,
  output logic [1:0]                         proc2mem_command,
  output logic [TAG_BITS+INDEX_BITS+2:0]     proc2mem_addr,
  output logic [63:0]                        proc2mem_data,
  input  logic [3:0]                         mem2proc_response,
  input  logic [63:0]                        mem2proc_data,
  input  logic [3:0]                         mem2proc_tag,
  output logic                               busy,
  output logic [CNT_W-1:0]                   hit_count,
  output logic [CNT_W-1:0]                   miss_count
);

  localparam int ADDR_W = TAG_BITS + INDEX_BITS + 3;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_is_st;
  logic                  r_rr_last_st;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INDEX_BITS-1:0] r_index;
  logic [63:0]           r_data;
  logic [TAG_BITS-1:0]   r_vic_tag;
  logic [63:0]           r_vic_data;
  logic [3:0]            r_pend_tag;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic [CNT_W-1:0]      r_miss_cnt;

  logic                  w_idle;
  logic                  w_ld_win;
  logic                  w_st_win;
  logic [ADDR_W-1:0]     w_req_addr;
  logic                  w_fill_match;
  logic                  w_unused_bits;

  // Load wins unless a store is also waiting and the load port was served last.
  assign w_idle       = (r_state == S_IDLE);
  assign w_ld_win     = ld_req_valid && (!st_req_valid || r_rr_last_st);
  assign w_st_win     = st_req_valid && !w_ld_win;
  assign w_req_addr   = w_st_win ? st_req_addr : ld_req_addr;
  assign w_fill_match = (r_state == S_FILL_WAIT) && (r_pend_tag != 4'd0) &&
                        (mem2proc_tag == r_pend_tag);
  assign w_unused_bits = ^{ld_req_addr[2:0], st_req_addr[2:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_is_st      <= 1'b0;
      r_rr_last_st <= 1'b1;
      r_tag        <= '0;
      r_index      <= '0;
      r_data       <= '0;
      r_vic_tag    <= '0;
      r_vic_data   <= '0;
      r_pend_tag   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ld_win || w_st_win) begin
            r_is_st      <= w_st_win;
            r_rr_last_st <= w_st_win;
            r_tag        <= w_req_addr[ADDR_W-1 -: TAG_BITS];
            r_index      <= w_req_addr[INDEX_BITS+2:3];
            if (w_st_win) r_data <= st_req_data;
            r_state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (cache_hit) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (!r_is_st) r_data <= cache_rd_data;
            r_state   <= S_RESP;
          end else begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            if (cache_victim_dirty) begin
              r_vic_tag  <= cache_victim_tag;
              r_vic_data <= cache_victim_data;
              r_state    <= S_WB_REQ;
            end else begin
              r_state    <= S_FILL_REQ;
            end
          end
        end
        S_WB_REQ: begin
          if (mem2proc_response != 4'd0) r_state <= S_FILL_REQ;
        end
        S_FILL_REQ: begin
          if (mem2proc_response != 4'd0) begin
            r_pend_tag <= mem2proc_response;
            r_state    <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (w_fill_match) begin
            if (!r_is_st) r_data <= mem2proc_data;
            r_pend_tag <= 4'd0;
            r_state    <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_req_ready  = w_idle && w_ld_win;
  assign st_req_ready  = w_idle && w_st_win;
  assign ld_resp_valid = (r_state == S_RESP) && !r_is_st;
  assign ld_resp_data  = ld_resp_valid ? r_data : 64'd0;
  assign st_done       = (r_state == S_RESP) && r_is_st;

  assign cache_index   = r_index;
  assign cache_tag     = r_tag;
  assign cache_lookup  = (r_state == S_LOOKUP);
  assign cache_wr_en   = cache_lookup && cache_hit && r_is_st;
  assign cache_fill_en = w_fill_match;
  assign cache_fill_dirty = w_fill_match && r_is_st;

  // Store data comes from the latched request; load fills pass memory data straight through.
  always_comb begin
    cache_wr_data = 64'd0;
    if (r_state == S_LOOKUP && r_is_st)
      cache_wr_data = r_data;
    else if (w_fill_match)
      cache_wr_data = r_is_st ? r_data : mem2proc_data;
  end

  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = 64'd0;
    if (r_state == S_WB_REQ) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = {r_vic_tag, r_index, 3'b000};
      proc2mem_data    = r_vic_data;
    end else if (r_state == S_FILL_REQ) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = {r_tag, r_index, 3'b000};
    end
  end

  assign busy       = !w_idle;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
